// File: rtl/stego_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// stego_ctrl_fsm
//   Job sequencer for the steganography core. Latches mode, LSB depth and the
//   job sizes once per job, fires a one-cycle start pulse into the
//   embed/extract datapath, counts output beats, watches for stalls and
//   reports done/busy/error/aborted/timeout status to the register bank.
//
// Ports
//   clk             system clock
//   reset           asynchronous active-low reset
//   control_signal  [0] enable (0 = soft reset), [1] start, [2] sgp_mode,
//                   [3] ps_enb, [4+:LSB_SEL_W] lsb_sel, [7] abort
//   picture_size    pixel bytes available in the cover image
//   message_size    symbols to embed/extract
//   respond_signal  [0] done, [1] busy, [2] error, [3] aborted, [4] timeout
//   out_beat        one output word accepted downstream this cycle
//   out_finish      datapath end-of-job flag
//   dp_reset        active-high datapath reset
//   dp_start        one-cycle job start pulse
//   sgp_mode        latched mode (0 embed, 1 extract); out_sel mirrors it
//   ps_enb          pass-through of control_signal[3]
//   lsb_depth       latched depth 1/2/4/8
//   pixel_size, secret_size, output_size   latched job sizes
// ---------------------------------------------------------------------------
module stego_ctrl_fsm #(
    parameter int REG_WIDTH    = 32,
    parameter int BITS_PER_SYM = 8,
    parameter int LSB_SEL_W    = 2,
    parameter int TIMEOUT      = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_WIDTH-1:0] control_signal,
    input  logic [REG_WIDTH-1:0] picture_size,
    input  logic [REG_WIDTH-1:0] message_size,
    output logic [REG_WIDTH-1:0] respond_signal,
    input  logic                 out_beat,
    input  logic                 out_finish,
    output logic                 dp_reset,
    output logic                 dp_start,
    output logic                 sgp_mode,
    output logic                 ps_enb,
    output logic [3:0]           lsb_depth,
    output logic                 out_sel,
    output logic [REG_WIDTH-1:0] pixel_size,
    output logic [REG_WIDTH-1:0] secret_size,
    output logic [REG_WIDTH-1:0] output_size
);

    localparam int WIDE_W = 2 * REG_WIDTH;
    localparam int WD_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_RUN, S_DONE, S_ERROR, S_ABORT, S_HOLD
    } state_t;

    // Pixels needed to carry msg symbols at 2^sel bits per pixel, rounded up.
    function automatic logic [WIDE_W-1:0] ceil_pix(input logic [REG_WIDTH-1:0] msg,
                                                   input logic [LSB_SEL_W-1:0] sel);
        logic [WIDE_W-1:0] bits;
        logic [WIDE_W-1:0] depth;
        bits  = WIDE_W'(msg) * WIDE_W'(BITS_PER_SYM);
        depth = WIDE_W'(1) << sel;
        return (bits + depth - WIDE_W'(1)) >> sel;
    endfunction

    state_t                 state_q;
    logic                   start_prev_q;
    logic                   mode_q;
    logic [LSB_SEL_W-1:0]   lsb_sel_q;
    logic [3:0]             lsb_depth_q;
    logic [REG_WIDTH-1:0]   beat_cnt_q;
    logic [WD_W-1:0]        wd_cnt_q;
    logic                   done_q, busy_q, error_q, aborted_q, timeout_q;
    logic                   dp_reset_q, dp_start_q;
    logic [REG_WIDTH-1:0]   pixel_q, secret_q, output_q;

    logic                   start_edge_d;
    logic [WIDE_W-1:0]      pix_d;
    logic                   bad_size_d;
    logic                   unused_ctl;

    assign start_edge_d = control_signal[1] & ~start_prev_q;
    assign pix_d        = ceil_pix(message_size, lsb_sel_q);
    // Upper-half test catches sizes that do not fit the output registers.
    assign bad_size_d   = (message_size == '0) ||
                          (pix_d > WIDE_W'(picture_size)) ||
                          (pix_d[WIDE_W-1:REG_WIDTH] != '0);
    assign unused_ctl   = ^{control_signal[REG_WIDTH-1:8], control_signal[6]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            // Treat start as already high so a level held through reset never fires.
            start_prev_q <= 1'b1;
            mode_q       <= 1'b0;
            lsb_sel_q    <= '0;
            lsb_depth_q  <= '0;
            beat_cnt_q   <= '0;
            wd_cnt_q     <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
            aborted_q    <= 1'b0;
            timeout_q    <= 1'b0;
            dp_reset_q   <= 1'b1;
            dp_start_q   <= 1'b0;
            pixel_q      <= '0;
            secret_q     <= '0;
            output_q     <= '0;
        end else if (!control_signal[0]) begin
            state_q      <= S_IDLE;
            // Keep tracking start so releasing soft reset with start high is not an edge.
            start_prev_q <= control_signal[1];
            mode_q       <= 1'b0;
            lsb_sel_q    <= '0;
            lsb_depth_q  <= '0;
            beat_cnt_q   <= '0;
            wd_cnt_q     <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
            aborted_q    <= 1'b0;
            timeout_q    <= 1'b0;
            dp_reset_q   <= 1'b1;
            dp_start_q   <= 1'b0;
            pixel_q      <= '0;
            secret_q     <= '0;
            output_q     <= '0;
        end else begin
            start_prev_q <= control_signal[1];
            dp_start_q   <= 1'b0;
            dp_reset_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_edge_d) begin
                        done_q      <= 1'b0;
                        busy_q      <= 1'b0;
                        error_q     <= 1'b0;
                        aborted_q   <= 1'b0;
                        timeout_q   <= 1'b0;
                        mode_q      <= control_signal[2];
                        lsb_sel_q   <= control_signal[4 +: LSB_SEL_W];
                        lsb_depth_q <= 4'(1 << control_signal[4 +: LSB_SEL_W]);
                        state_q     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    pixel_q    <= pix_d[REG_WIDTH-1:0];
                    secret_q   <= mode_q ? '0 : message_size;
                    output_q   <= mode_q ? message_size : pix_d[REG_WIDTH-1:0];
                    beat_cnt_q <= '0;
                    wd_cnt_q   <= '0;
                    if (bad_size_d) begin
                        error_q <= 1'b1;
                        state_q <= S_ERROR;
                    end else begin
                        busy_q     <= 1'b1;
                        dp_start_q <= 1'b1;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (out_beat) begin
                        beat_cnt_q <= beat_cnt_q + REG_WIDTH'(1);
                        wd_cnt_q   <= '0;
                    end else begin
                        wd_cnt_q   <= wd_cnt_q + WD_W'(1);
                    end
                    // Priority: abort, then finish, then watchdog.
                    if (control_signal[7]) begin
                        aborted_q  <= 1'b1;
                        busy_q     <= 1'b0;
                        dp_reset_q <= 1'b1;
                        state_q    <= S_ABORT;
                    end else if (out_finish ||
                                 (out_beat && beat_cnt_q == output_q - REG_WIDTH'(1))) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
                        error_q   <= 1'b1;
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_ERROR;
                    end
                end
                S_ABORT: begin
                    state_q <= S_HOLD;
                end
                S_DONE, S_ERROR, S_HOLD: begin
                    if (!control_signal[1]) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign respond_signal = {{(REG_WIDTH-5){1'b0}}, timeout_q, aborted_q, error_q, busy_q, done_q};
    assign dp_reset       = dp_reset_q;
    assign dp_start       = dp_start_q;
    assign sgp_mode       = mode_q;
    assign out_sel        = mode_q;
    assign lsb_depth      = lsb_depth_q;
    assign ps_enb         = control_signal[3] & control_signal[0] & reset;
    assign pixel_size     = pixel_q;
    assign secret_size    = secret_q;
    assign output_size    = output_q;

endmodule

// File: tb/tb_stego_ctrl_fsm.sv
module tb_stego_ctrl_fsm;

    localparam int RW = 32;
    localparam int TO = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [RW-1:0] cs = '0, pic = '0, msg = '0;
    logic          out_beat = 1'b0, out_finish = 1'b0;
    logic [RW-1:0] respond, pixel_size, secret_size, output_size;
    logic          dp_reset, dp_start, sgp_mode, ps_enb, out_sel;
    logic [3:0]    lsb_depth;

    int checks = 0;
    int errors = 0;

    stego_ctrl_fsm #(.REG_WIDTH(RW), .BITS_PER_SYM(8), .LSB_SEL_W(2), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .control_signal(cs), .picture_size(pic),
        .message_size(msg), .respond_signal(respond), .out_beat(out_beat),
        .out_finish(out_finish), .dp_reset(dp_reset), .dp_start(dp_start),
        .sgp_mode(sgp_mode), .ps_enb(ps_enb), .lsb_depth(lsb_depth), .out_sel(out_sel),
        .pixel_size(pixel_size), .secret_size(secret_size), .output_size(output_size)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [31:0] pic;
        logic [31:0] msg;
        logic        err;
        logic [31:0] px;
        logic [31:0] sec;
        logic [31:0] osz;
        logic [3:0]  dep;
    } vec_t;

    vec_t tv[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] ctl(input logic en, input logic st, input logic mode,
                                          input logic ps, input logic [1:0] sel, input logic ab);
        return RW'({ab, 1'b0, sel, ps, mode, st, en});
    endfunction

    // Start low for one cycle, then raise start; returns one cycle after the edge (CHECK).
    task automatic launch(input logic mode, input logic [1:0] sel,
                          input logic [31:0] p, input logic [31:0] m);
        cs  = ctl(1'b1, 1'b0, mode, 1'b0, sel, 1'b0);
        pic = p;
        msg = m;
        step();
        cs[1] = 1'b1;
        step();
    endtask

    initial begin
        int nb;
        logic saw;

        //            mode sel  pic           msg           err  pix          sec   out          dep
        tv[0] = '{1'b0, 2'd0, 32'd100,      32'd10,       1'b0, 32'd80,      32'd10, 32'd80,    4'd1};
        tv[1] = '{1'b1, 2'd1, 32'd100,      32'd10,       1'b0, 32'd40,      32'd0,  32'd10,    4'd2};
        tv[2] = '{1'b0, 2'd0, 32'd100,      32'd20,       1'b1, 32'd0,       32'd0,  32'd0,     4'd1};
        tv[3] = '{1'b0, 2'd2, 32'd100,      32'd3,        1'b0, 32'd6,       32'd3,  32'd6,     4'd4};
        tv[4] = '{1'b0, 2'd3, 32'd1,        32'd1,        1'b0, 32'd1,       32'd1,  32'd1,     4'd8};
        tv[5] = '{1'b0, 2'd1, 32'd100,      32'd0,        1'b1, 32'd0,       32'd0,  32'd0,     4'd2};
        tv[6] = '{1'b1, 2'd3, 32'd4,        32'd5,        1'b1, 32'd0,       32'd0,  32'd0,     4'd8};
        tv[7] = '{1'b1, 2'd3, 32'hFFFFFFFF, 32'h10000000, 1'b0, 32'h10000000, 32'd0, 32'h10000000, 4'd8};

        // Hard reset state
        cs = ctl(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        #12;
        chk("rst_dp_reset", 64'(dp_reset), 64'd1);
        chk("rst_respond", 64'(respond), 64'd0);
        chk("rst_dp_start", 64'(dp_start), 64'd0);
        chk("rst_sizes", 64'(pixel_size | secret_size | output_size), 64'd0);
        chk("rst_mode_bits", 64'({sgp_mode, out_sel, ps_enb, lsb_depth}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("idle_dp_reset", 64'(dp_reset), 64'd0);
        chk("idle_ps_enb", 64'(ps_enb), 64'd1);

        // Table of single jobs: size computation, error decision, start pulse
        for (int i = 0; i < 8; i++) begin
            launch(tv[i].mode, tv[i].sel, tv[i].pic, tv[i].msg);
            chk($sformatf("v%0d_status_clear", i), 64'(respond), 64'd0);
            chk($sformatf("v%0d_no_start_in_check", i), 64'(dp_start), 64'd0);
            step();
            chk($sformatf("v%0d_error", i), 64'(respond[2]), 64'(tv[i].err));
            chk($sformatf("v%0d_dp_start", i), 64'(dp_start), 64'(!tv[i].err));
            chk($sformatf("v%0d_busy", i), 64'(respond[1]), 64'(!tv[i].err));
            chk($sformatf("v%0d_depth", i), 64'(lsb_depth), 64'(tv[i].dep));
            chk($sformatf("v%0d_out_sel", i), 64'(out_sel), 64'(tv[i].mode));
            if (!tv[i].err) begin
                chk($sformatf("v%0d_pixel", i), 64'(pixel_size), 64'(tv[i].px));
                chk($sformatf("v%0d_secret", i), 64'(secret_size), 64'(tv[i].sec));
                chk($sformatf("v%0d_output", i), 64'(output_size), 64'(tv[i].osz));
                step();
                chk($sformatf("v%0d_start_one_cycle", i), 64'(dp_start), 64'd0);
                out_finish = 1'b1;
                step();
                out_finish = 1'b0;
                chk($sformatf("v%0d_done", i), 64'(respond), 64'h1);
            end else begin
                step();
                chk($sformatf("v%0d_err_resp", i), 64'(respond), 64'h4);
            end
            cs[1] = 1'b0;
            step();
        end

        // Embed: done on the 80th beat, register changes mid-job ignored
        launch(1'b0, 2'd0, 32'd100, 32'd10);
        step();
        msg = 32'd7;
        cs[2] = 1'b1;
        nb = 0;
        for (int k = 0; k < 200; k++) begin
            out_beat = 1'b1;
            step();
            nb++;
            if (respond[0]) break;
        end
        out_beat = 1'b0;
        chk("embed_beats", 64'(nb), 64'd80);
        chk("embed_resp", 64'(respond), 64'h1);
        chk("embed_frozen_out", 64'(output_size), 64'd80);
        chk("embed_frozen_mode", 64'(sgp_mode), 64'd0);
        cs[1] = 1'b0;
        step();

        // Extract: done on the 10th beat
        launch(1'b1, 2'd1, 32'd100, 32'd10);
        step();
        chk("extract_out_sel", 64'(out_sel), 64'd1);
        nb = 0;
        for (int k = 0; k < 50; k++) begin
            out_beat = 1'b1;
            step();
            nb++;
            if (respond[0]) break;
        end
        out_beat = 1'b0;
        chk("extract_beats", 64'(nb), 64'd10);
        cs[1] = 1'b0;
        step();

        // Abort at beat 5, simultaneous with finish: abort wins
        launch(1'b0, 2'd0, 32'd100, 32'd10);
        step();
        for (int k = 0; k < 5; k++) begin
            out_beat = 1'b1;
            step();
        end
        out_beat = 1'b0;
        cs[7] = 1'b1;
        out_finish = 1'b1;
        step();
        cs[7] = 1'b0;
        out_finish = 1'b0;
        chk("abort_resp", 64'(respond), 64'h8);
        chk("abort_dp_reset_hi", 64'(dp_reset), 64'd1);
        step();
        chk("abort_dp_reset_lo", 64'(dp_reset), 64'd0);
        step();
        chk("hold_dp_reset_lo", 64'(dp_reset), 64'd0);
        chk("hold_resp", 64'(respond), 64'h8);
        cs[1] = 1'b0;
        step();
        cs[7] = 1'b1;
        step();
        chk("idle_abort_no_effect", 64'(respond), 64'h8);
        cs[7] = 1'b0;
        cs[1] = 1'b1;
        step();
        chk("restart_clears_status", 64'(respond), 64'h0);
        step();
        chk("restart_dp_start", 64'(dp_start), 64'd1);
        out_finish = 1'b1;
        step();
        out_finish = 1'b0;
        cs[1] = 1'b0;
        step();

        // Stall: watchdog fires after TO beat-less RUN cycles
        launch(1'b0, 2'd0, 32'd100, 32'd10);
        step();
        nb = 0;
        for (int k = 0; k < TO + 20; k++) begin
            step();
            nb++;
            if (respond[2]) break;
        end
        chk("stall_cycles", 64'(nb), 64'(TO));
        chk("stall_resp", 64'(respond), 64'h14);
        cs[1] = 1'b0;
        step();

        // Finish coinciding with watchdog expiry: finish wins
        launch(1'b0, 2'd0, 32'd100, 32'd10);
        step();
        repeat (TO - 1) step();
        out_finish = 1'b1;
        step();
        out_finish = 1'b0;
        chk("finish_beats_timeout", 64'(respond), 64'h1);
        cs[1] = 1'b0;
        step();

        // Hard reset mid-RUN, start held high through release
        launch(1'b0, 2'd0, 32'd100, 32'd10);
        step();
        out_beat = 1'b1;
        repeat (3) step();
        out_beat = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("hrst_dp_reset", 64'(dp_reset), 64'd1);
        chk("hrst_resp", 64'(respond), 64'd0);
        chk("hrst_sizes", 64'(pixel_size | secret_size | output_size), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (dp_start || respond[1]) saw = 1'b1;
        end
        chk("hrst_no_restart", 64'(saw), 64'd0);
        chk("hrst_resp_after", 64'(respond), 64'd0);

        // Soft reset mid-RUN, start held high through release
        cs[1] = 1'b0;
        step();
        launch(1'b1, 2'd2, 32'd100, 32'd10);
        step();
        out_beat = 1'b1;
        repeat (3) step();
        out_beat = 1'b0;
        cs[0] = 1'b0;
        cs[3] = 1'b1;
        step();
        chk("srst_dp_reset", 64'(dp_reset), 64'd1);
        chk("srst_resp", 64'(respond), 64'd0);
        chk("srst_sizes", 64'(pixel_size | secret_size | output_size), 64'd0);
        chk("srst_mode_bits", 64'({sgp_mode, out_sel, ps_enb, lsb_depth}), 64'd0);
        step();
        chk("srst_held", 64'(dp_reset), 64'd1);
        cs[0] = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (dp_start || respond[1]) saw = 1'b1;
        end
        chk("srst_no_restart", 64'(saw), 64'd0);
        chk("srst_dp_reset_released", 64'(dp_reset), 64'd0);
        chk("srst_ps_enb", 64'(ps_enb), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
